servo_dispense_ctrl: RTL

- Downstream consumer of the dispense-time stage. Takes the one-cycle morning/afternoon/evening dispense pulses, gates them with per-slot enables, and queues them.
- Serialises the queued requests and drives one hobby-servo gate on a GPIO pin with a 50 Hz PWM signal. Per request: open for a hold time, close, settle.
- Keeps a dose inventory counter. Reports busy, completion, empty and missed-request status to the top level for LEDR display.

---
 rtl/servo_dispense_ctrl_if.sv | 37 +++
 rtl/servo_dispense_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/servo_dispense_ctrl_if.sv
// Request/status bundle between the dispense-time stage, the servo controller and the LED display.
// Requests and refill are single-cycle pulses; the controller samples them on every clock edge
// and never stalls them, so there is no ready side: an unacceptable request shows up on missed.
interface servo_dispense_if #(
    parameter int DOSE_W = 4
) ();
    logic              req_morning;
    logic              req_afternoon;
    logic              req_evening;
    logic              en_morning;
    logic              en_afternoon;
    logic              en_evening;
    logic              refill;
    logic [DOSE_W-1:0] refill_count;
    logic              servo_pwm;
    logic              busy;
    logic              dispensed;
    logic              missed;
    logic              empty;
    logic [DOSE_W-1:0] dose_count;
    logic [2:0]        pending;
    logic [2:0]        state_dbg;

    modport master (
        output req_morning, req_afternoon, req_evening,
        output en_morning, en_afternoon, en_evening,
        output refill, refill_count,
        input  servo_pwm, busy, dispensed, missed, empty, dose_count, pending, state_dbg
    );

    modport slave (
        input  req_morning, req_afternoon, req_evening,
        input  en_morning, en_afternoon, en_evening,
        input  refill, refill_count,
        output servo_pwm, busy, dispensed, missed, empty, dose_count, pending, state_dbg
    );
endinterface

// File: rtl/servo_dispense_ctrl.sv
// Latches gated dispense requests, serialises them by slot priority and drives a 50 Hz hobby-servo
// gate through open/hold/close/settle, while tracking the remaining dose inventory.
module servo_dispense_ctrl #(
    parameter int PWM_PERIOD    = 1000000,
    parameter int PULSE_CLOSED  = 50000,
    parameter int PULSE_OPEN    = 100000,
    parameter int OPEN_FRAMES   = 50,
    parameter int SETTLE_FRAMES = 25,
    parameter int DOSE_W        = 4
) (
    input  logic              clock,
    input  logic              reset,
    servo_dispense_if.slave   bus
);
    localparam int CNT_W  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int MAX_FR = (OPEN_FRAMES > SETTLE_FRAMES) ? OPEN_FRAMES : SETTLE_FRAMES;
    localparam int FR_W   = $clog2(MAX_FR + 1);

    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(PWM_PERIOD - 1);
    localparam logic [CNT_W-1:0] W_CLOSED     = CNT_W'(PULSE_CLOSED);
    localparam logic [CNT_W-1:0] W_OPEN       = CNT_W'(PULSE_OPEN);
    localparam logic [FR_W-1:0]  OPEN_LAST    = FR_W'(OPEN_FRAMES - 1);
    localparam logic [FR_W-1:0]  SETTLE_LAST  = FR_W'(SETTLE_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_OPEN_WAIT = 3'd1,
        S_OPEN      = 3'd2,
        S_SETTLE    = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  frame_cnt;
    logic              frame_tick;
    logic [CNT_W-1:0]  width_q, width_d;
    logic [FR_W-1:0]   frames_q, frames_d;
    logic              busy_q, busy_d;
    logic              pwm_q;
    logic              missed_q;
    logic [2:0]        pending_q;
    logic [DOSE_W-1:0] dose_q;

    logic [2:0]        req_hit;
    logic [2:0]        dup;
    logic [2:0]        sel;
    logic [2:0]        clr;
    logic              dec;
    logic              drop;

    assign frame_tick = (frame_cnt == CNT_LAST);

    // width_reg only moves on the frame boundary, so every emitted pulse is whole.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
            pwm_q     <= 1'b0;
        end else begin
            frame_cnt <= frame_tick ? '0 : frame_cnt + CNT_W'(1);
            pwm_q     <= (frame_cnt < width_q);
        end
    end

    assign req_hit = {bus.req_evening   & bus.en_evening,
                      bus.req_afternoon & bus.en_afternoon,
                      bus.req_morning   & bus.en_morning};
    assign dup     = req_hit & pending_q;

    always_comb begin
        sel = 3'b000;
        if (pending_q[0])      sel = 3'b001;
        else if (pending_q[1]) sel = 3'b010;
        else if (pending_q[2]) sel = 3'b100;
    end

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        frames_d = frames_q;
        busy_d   = busy_q;
        clr      = 3'b000;
        dec      = 1'b0;
        drop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // busy drops here unless a new request is accepted in the same cycle.
                busy_d = 1'b0;
                if (sel != 3'b000) begin
                    clr = sel;
                    if (dose_q != '0) begin
                        dec     = 1'b1;
                        busy_d  = 1'b1;
                        state_d = S_OPEN_WAIT;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            S_OPEN_WAIT: begin
                if (frame_tick) begin
                    width_d  = W_OPEN;
                    frames_d = '0;
                    state_d  = S_OPEN;
                end
            end
            S_OPEN: begin
                if (frame_tick) begin
                    if (frames_q == OPEN_LAST) begin
                        width_d  = W_CLOSED;
                        frames_d = '0;
                        state_d  = S_SETTLE;
                    end else begin
                        frames_d = frames_q + FR_W'(1);
                    end
                end
            end
            S_SETTLE: begin
                if (frame_tick) begin
                    if (frames_q == SETTLE_LAST) begin
                        frames_d = '0;
                        state_d  = S_DONE;
                    end else begin
                        frames_d = frames_q + FR_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            width_q   <= W_CLOSED;
            frames_q  <= '0;
            busy_q    <= 1'b0;
            missed_q  <= 1'b0;
            pending_q <= 3'b000;
            dose_q    <= '0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            frames_q  <= frames_d;
            busy_q    <= busy_d;
            // A request hitting an already-latched slot is dropped, even if that slot is being served now.
            pending_q <= (pending_q & ~clr) | (req_hit & ~pending_q);
            missed_q  <= (dup != 3'b000) | drop;
            if (bus.refill)
                dose_q <= bus.refill_count;
            else if (dec)
                dose_q <= dose_q - DOSE_W'(1);
        end
    end

    assign bus.servo_pwm  = pwm_q;
    assign bus.busy       = busy_q;
    assign bus.dispensed  = (state_q == S_DONE);
    assign bus.missed     = missed_q;
    assign bus.empty      = (dose_q == '0);
    assign bus.dose_count = dose_q;
    assign bus.pending    = pending_q;
    assign bus.state_dbg  = state_q;
endmodule
